// File: rtl/conv_layer_seq_pkg.sv
// Shared definitions for the layer sequencer: default widths, the FSM state
// encoding and the per-instruction weight stride helper.
package conv_layer_seq_pkg;

    localparam int DefAddrWidth  = 32;
    localparam int DefPictWidth  = 9;
    localparam int DefPixelNum   = 18;
    localparam int DefChWidth    = 10;
    localparam int DefKernelSize = 9;
    localparam int DefInputDim   = 4;

    // Weight words consumed by one instruction (InputDim kernels of KernelSize).
    function automatic int weight_stride(input int input_dim, input int kernel_size);
        return input_dim * kernel_size;
    endfunction

    localparam int DefWeightStride = DefInputDim * DefKernelSize;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_ISSUE = 3'd2,
        ST_WAIT  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/conv_layer_seq_if.sv
// Host-config / instruction bus of the layer sequencer.
// master = host + convolution controller side, slave = sequencer.
// Optional CONV_SEQ_PERF_EN adds the performance counter outputs.
interface conv_layer_seq_if
    import conv_layer_seq_pkg::*;
#(
    parameter int MaxAddrWidth = DefAddrWidth,
    parameter int MaxPictWidth = DefPictWidth,
    parameter int MaxChWidth   = DefChWidth
);
    logic                    start_in;
    logic [MaxChWidth-1:0]   in_groups_in;
    logic [MaxChWidth-1:0]   out_ch_in;
    logic [MaxAddrWidth-1:0] weight_base_in;
    logic [MaxAddrWidth-1:0] data_base_in;
    logic [MaxPictWidth-1:0] pict_size_in;
    logic                    conv_done_in;

    logic [MaxAddrWidth-1:0] weight_addr0_out;
    logic [MaxAddrWidth-1:0] weight_addr1_out;
    logic [MaxAddrWidth-1:0] weight_addr2_out;
    logic [MaxAddrWidth-1:0] weight_addr3_out;
    logic [MaxAddrWidth-1:0] data_addr0_out;
    logic [MaxAddrWidth-1:0] data_addr1_out;
    logic [MaxAddrWidth-1:0] data_addr2_out;
    logic [MaxAddrWidth-1:0] data_addr3_out;
    logic [MaxPictWidth-1:0] pict_size_out;
    logic                    conv_first_out;
    logic                    conv_last_out;
    logic                    inst_tag_out;
    logic                    busy_out;
    logic                    layer_done_out;
`ifdef CONV_SEQ_PERF_EN
    logic [31:0]             perf_cycles_out;
    logic [2*MaxChWidth-1:0] perf_insts_out;
`endif

    modport master (
        output start_in, in_groups_in, out_ch_in, weight_base_in, data_base_in,
               pict_size_in, conv_done_in,
        input  weight_addr0_out, weight_addr1_out, weight_addr2_out, weight_addr3_out,
               data_addr0_out, data_addr1_out, data_addr2_out, data_addr3_out,
               pict_size_out, conv_first_out, conv_last_out, inst_tag_out,
               busy_out, layer_done_out
`ifdef CONV_SEQ_PERF_EN
        , input perf_cycles_out, perf_insts_out
`endif
    );

    modport slave (
        input  start_in, in_groups_in, out_ch_in, weight_base_in, data_base_in,
               pict_size_in, conv_done_in,
        output weight_addr0_out, weight_addr1_out, weight_addr2_out, weight_addr3_out,
               data_addr0_out, data_addr1_out, data_addr2_out, data_addr3_out,
               pict_size_out, conv_first_out, conv_last_out, inst_tag_out,
               busy_out, layer_done_out
`ifdef CONV_SEQ_PERF_EN
        , output perf_cycles_out, perf_insts_out
`endif
    );

endinterface

// File: rtl/conv_layer_seq_addr_gen.sv
// conv_addr_gen: registers the four kernel bases and four plane bases of one
// instruction from the current weight/data pointers and the plane size.
module conv_addr_gen
    import conv_layer_seq_pkg::*;
#(
    parameter int MaxAddrWidth = DefAddrWidth,
    parameter int MaxPixelNum  = DefPixelNum,
    parameter int KernelSize   = DefKernelSize
) (
    input  logic                    Clk,
    input  logic                    Rst_n,
    input  logic                    load,
    input  logic [MaxAddrWidth-1:0] w_ptr,
    input  logic [MaxAddrWidth-1:0] d_ptr,
    input  logic [MaxPixelNum-1:0]  pix_num,
    output logic [MaxAddrWidth-1:0] weight_addr [4],
    output logic [MaxAddrWidth-1:0] data_addr [4]
);

    // Capture all eight addresses on the issue cycle; sums wrap modulo 2^MaxAddrWidth.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            for (int k = 0; k < 4; k++) begin
                weight_addr[k] <= '0;
                data_addr[k]   <= '0;
            end
        end else if (load) begin
            for (int k = 0; k < 4; k++) begin
                weight_addr[k] <= w_ptr + MaxAddrWidth'(k * KernelSize);
                data_addr[k]   <= d_ptr + MaxAddrWidth'(pix_num) * MaxAddrWidth'(k);
            end
        end
    end

endmodule

// File: rtl/conv_layer_seq.sv
// conv_layer_seq: walks every output channel x input-channel group of a layer,
// issuing one convolution instruction per step and waiting for its completion.
// Optional macro CONV_SEQ_PERF_EN adds busy-cycle and issued-instruction counters.
//
// state | meaning
// IDLE  | waiting for start_in, config latched on acceptance
// SETUP | square the side length, clear counters and pointers
// ISSUE | register the instruction addresses/flags, toggle inst_tag
// WAIT  | wait for conv_done_in, then advance group/channel
// DONE  | one-cycle layer_done pulse
module conv_layer_seq
    import conv_layer_seq_pkg::*;
#(
    parameter int MaxAddrWidth = DefAddrWidth,
    parameter int MaxPictWidth = DefPictWidth,
    parameter int MaxPixelNum  = DefPixelNum,
    parameter int MaxChWidth   = DefChWidth,
    parameter int KernelSize   = DefKernelSize,
    parameter int InputDim     = DefInputDim
) (
    input logic             Clk,
    input logic             Rst_n,
    conv_layer_seq_if.slave bus
);

    localparam logic [MaxAddrWidth-1:0] WStep =
        MaxAddrWidth'(weight_stride(InputDim, KernelSize));
    localparam logic [MaxChWidth-1:0] ChOne = MaxChWidth'(1);

    state_t state, state_nxt;

    logic [MaxChWidth-1:0]   in_groups_r, out_ch_r, oc, g;
    logic [MaxAddrWidth-1:0] weight_base_r, data_base_r, w_ptr, d_ptr;
    logic [MaxPictWidth-1:0] pict_r;
    logic [MaxPixelNum-1:0]  pix_num, pict_ext;
    logic                    first_r, last_r, tag_r;
    logic                    busy, layer_done, issue_en, start_acc, done_acc;
    logic                    grp_last, oc_last;
    logic [MaxAddrWidth-1:0] w_addr [4];
    logic [MaxAddrWidth-1:0] d_addr [4];

    assign pict_ext = MaxPixelNum'(pict_r);
    assign grp_last = (g == in_groups_r - ChOne);
    assign oc_last  = (oc == out_ch_r - ChOne);

    // State register.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic; start and done pulses only count in IDLE and WAIT.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.start_in) state_nxt = ST_SETUP;
            ST_SETUP: state_nxt = (in_groups_r == '0 || out_ch_r == '0) ? ST_DONE : ST_ISSUE;
            ST_ISSUE: state_nxt = ST_WAIT;
            ST_WAIT:  if (bus.conv_done_in) state_nxt = (grp_last && oc_last) ? ST_DONE : ST_ISSUE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // State-decoded outputs and strobes.
    always_comb begin
        busy       = (state != ST_IDLE);
        layer_done = (state == ST_DONE);
        issue_en   = (state == ST_ISSUE);
        start_acc  = (state == ST_IDLE) && bus.start_in;
        done_acc   = (state == ST_WAIT) && bus.conv_done_in;
    end

    // Config latch, loop counters, pointers and instruction flags.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            in_groups_r   <= '0;
            out_ch_r      <= '0;
            weight_base_r <= '0;
            data_base_r   <= '0;
            pict_r        <= '0;
            pix_num       <= '0;
            oc            <= '0;
            g             <= '0;
            w_ptr         <= '0;
            d_ptr         <= '0;
            first_r       <= 1'b0;
            last_r        <= 1'b0;
            tag_r         <= 1'b0;
        end else begin
            if (start_acc) begin
                in_groups_r   <= bus.in_groups_in;
                out_ch_r      <= bus.out_ch_in;
                weight_base_r <= bus.weight_base_in;
                data_base_r   <= bus.data_base_in;
                pict_r        <= bus.pict_size_in;
            end
            if (state == ST_SETUP) begin
                pix_num <= pict_ext * pict_ext;
                oc      <= '0;
                g       <= '0;
                w_ptr   <= weight_base_r;
                d_ptr   <= data_base_r;
            end
            if (issue_en) begin
                first_r <= (g == '0);
                last_r  <= grp_last;
                tag_r   <= ~tag_r;
            end
            if (done_acc) begin
                w_ptr <= w_ptr + WStep;
                if (!grp_last) begin
                    g     <= g + ChOne;
                    d_ptr <= d_ptr + MaxAddrWidth'(pix_num) * MaxAddrWidth'(InputDim);
                end else begin
                    g     <= '0;
                    d_ptr <= data_base_r;
                    oc    <= oc + ChOne;
                end
            end
        end
    end

    conv_addr_gen #(
        .MaxAddrWidth (MaxAddrWidth),
        .MaxPixelNum  (MaxPixelNum),
        .KernelSize   (KernelSize)
    ) u_addr_gen (
        .Clk         (Clk),
        .Rst_n       (Rst_n),
        .load        (issue_en),
        .w_ptr       (w_ptr),
        .d_ptr       (d_ptr),
        .pix_num     (pix_num),
        .weight_addr (w_addr),
        .data_addr   (d_addr)
    );

    assign bus.weight_addr0_out = w_addr[0];
    assign bus.weight_addr1_out = w_addr[1];
    assign bus.weight_addr2_out = w_addr[2];
    assign bus.weight_addr3_out = w_addr[3];
    assign bus.data_addr0_out   = d_addr[0];
    assign bus.data_addr1_out   = d_addr[1];
    assign bus.data_addr2_out   = d_addr[2];
    assign bus.data_addr3_out   = d_addr[3];
    assign bus.pict_size_out    = pict_r;
    assign bus.conv_first_out   = first_r;
    assign bus.conv_last_out    = last_r;
    assign bus.inst_tag_out     = tag_r;
    assign bus.busy_out         = busy;
    assign bus.layer_done_out   = layer_done;

`ifdef CONV_SEQ_PERF_EN
    logic [31:0]             perf_cycles;
    logic [2*MaxChWidth-1:0] perf_insts;

    // Performance counters: cleared on start acceptance, held after the layer.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            perf_cycles <= '0;
            perf_insts  <= '0;
        end else if (start_acc) begin
            perf_cycles <= '0;
            perf_insts  <= '0;
        end else begin
            if (busy)     perf_cycles <= perf_cycles + 32'd1;
            if (issue_en) perf_insts  <= perf_insts + (2*MaxChWidth)'(1);
        end
    end

    assign bus.perf_cycles_out = perf_cycles;
    assign bus.perf_insts_out  = perf_insts;
`endif

endmodule

// File: tb/tb_conv_layer_seq.sv
// Self-checking bench for conv_layer_seq: each layer is checked against an
// instruction list computed from nested output-channel / group loops.
module tb_conv_layer_seq;
    import conv_layer_seq_pkg::*;

    logic Clk = 1'b0;
    logic Rst_n = 1'b0;
    always #5 Clk = ~Clk;

    conv_layer_seq_if bus ();

    conv_layer_seq dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [3:0][31:0] w;
        logic [3:0][31:0] d;
        logic             first;
        logic             last;
    } inst_t;

    function automatic logic [269:0] all_outs();
        return {bus.weight_addr0_out, bus.weight_addr1_out, bus.weight_addr2_out,
                bus.weight_addr3_out, bus.data_addr0_out, bus.data_addr1_out,
                bus.data_addr2_out, bus.data_addr3_out, bus.pict_size_out,
                bus.conv_first_out, bus.conv_last_out, bus.inst_tag_out,
                bus.busy_out, bus.layer_done_out};
    endfunction

    function automatic logic [31:0] got_w(input int k);
        case (k)
            0: return bus.weight_addr0_out;
            1: return bus.weight_addr1_out;
            2: return bus.weight_addr2_out;
            default: return bus.weight_addr3_out;
        endcase
    endfunction

    function automatic logic [31:0] got_d(input int k);
        case (k)
            0: return bus.data_addr0_out;
            1: return bus.data_addr1_out;
            2: return bus.data_addr2_out;
            default: return bus.data_addr3_out;
        endcase
    endfunction

    task automatic drive_idle();
        bus.start_in       = 1'b0;
        bus.in_groups_in   = '0;
        bus.out_ch_in      = '0;
        bus.weight_base_in = '0;
        bus.data_base_in   = '0;
        bus.pict_size_in   = '0;
        bus.conv_done_in   = 1'b0;
    endtask

    // Runs one whole layer; spur adds a start pulse during WAIT and a done
    // pulse held into the ISSUE cycle, both of which must be ignored.
    task automatic run_layer(input string name, input int ig, input int oc,
                             input logic [31:0] wb, input logic [31:0] db,
                             input int ps, input int dly, input bit spur);
        inst_t exp_q[$];
        inst_t e;
        logic [31:0] pix;
        int n_exp, issued, cyc, since, done_drv, done_cyc, busy_cnt, limit;
        bit outstanding, spur_hold, got_done;
        logic prev_tag;

        pix = (32'(ps) * 32'(ps)) & 32'h3FFFF;
        for (int o = 0; o < oc; o++) begin
            for (int gi = 0; gi < ig; gi++) begin
                for (int k = 0; k < 4; k++) begin
                    e.w[k] = wb + 32'((o * ig + gi) * 36) + 32'(9 * k);
                    e.d[k] = db + 32'(gi) * 32'd4 * pix + 32'(k) * pix;
                end
                e.first = (gi == 0);
                e.last  = (gi == ig - 1);
                exp_q.push_back(e);
            end
        end
        n_exp = exp_q.size();

        prev_tag = bus.inst_tag_out;
        bus.in_groups_in   = 10'(ig);
        bus.out_ch_in      = 10'(oc);
        bus.weight_base_in = wb;
        bus.data_base_in   = db;
        bus.pict_size_in   = 9'(ps);
        bus.start_in       = 1'b1;

        issued = 0; cyc = 0; since = 0; done_drv = -1; done_cyc = -1; busy_cnt = 0;
        outstanding = 0; spur_hold = 0; got_done = 0;
        limit = n_exp * (dly + 6) + 12;

        while (!got_done && cyc < limit) begin
            @(posedge Clk); #1;
            cyc++;
            bus.start_in     = 1'b0;
            bus.conv_done_in = spur_hold;
            spur_hold        = 1'b0;
            if (bus.busy_out === 1'b1) busy_cnt++;

            if (bus.inst_tag_out !== prev_tag) begin
                prev_tag = bus.inst_tag_out;
                n_checks++;
                if (issued >= n_exp) begin
                    n_errors++;
                    $display("FAIL %s extra_toggle: got toggle %0d, required %0d total", name, issued + 1, n_exp);
                end else begin
                    e = exp_q[issued];
                    for (int k = 0; k < 4; k++) begin
                        n_checks++;
                        if (got_w(k) !== e.w[k]) begin
                            n_errors++;
                            $display("FAIL %s weight_addr%0d inst %0d: got %h required %h", name, k, issued, got_w(k), e.w[k]);
                        end
                        n_checks++;
                        if (got_d(k) !== e.d[k]) begin
                            n_errors++;
                            $display("FAIL %s data_addr%0d inst %0d: got %h required %h", name, k, issued, got_d(k), e.d[k]);
                        end
                    end
                    n_checks++;
                    if ({bus.conv_first_out, bus.conv_last_out} !== {e.first, e.last}) begin
                        n_errors++;
                        $display("FAIL %s first_last inst %0d: got %b%b required %b%b", name, issued,
                                 bus.conv_first_out, bus.conv_last_out, e.first, e.last);
                    end
                    n_checks++;
                    if (bus.pict_size_out !== 9'(ps)) begin
                        n_errors++;
                        $display("FAIL %s pict_size inst %0d: got %0d required %0d", name, issued, bus.pict_size_out, ps);
                    end
                    n_checks++;
                    if (issued == 0 && cyc != 3) begin
                        n_errors++;
                        $display("FAIL %s start_latency: got %0d required 3", name, cyc);
                    end else if (issued > 0 && cyc - done_drv != 2) begin
                        n_errors++;
                        $display("FAIL %s done_latency inst %0d: got %0d required 2", name, issued, cyc - done_drv);
                    end
                end
                issued++;
                outstanding = 1;
                since = 0;
            end else if (outstanding) begin
                since++;
                if (spur && since == 1) begin
                    bus.start_in       = 1'b1;
                    bus.weight_base_in = $urandom;
                    bus.data_base_in   = $urandom;
                    bus.pict_size_in   = 9'($urandom_range(1, 511));
                end
                if (since == dly) begin
                    bus.conv_done_in = 1'b1;
                    spur_hold        = spur;
                    done_drv         = cyc;
                    outstanding      = 0;
                end
            end

            if (bus.layer_done_out === 1'b1) begin
                got_done = 1;
                done_cyc = cyc;
            end
        end
        bus.start_in     = 1'b0;
        bus.conv_done_in = 1'b0;

        n_checks++;
        if (!got_done) begin
            n_errors++;
            $display("FAIL %s layer_done_timeout: got none after %0d cycles, required pulse", name, cyc);
        end
        n_checks++;
        if (issued != n_exp) begin
            n_errors++;
            $display("FAIL %s inst_count: got %0d required %0d", name, issued, n_exp);
        end
        n_checks++;
        if (n_exp == 0 && (done_cyc != 2 || busy_cnt != 2)) begin
            n_errors++;
            $display("FAIL %s empty_layer: got done@%0d busy %0d required done@2 busy 2", name, done_cyc, busy_cnt);
        end else if (n_exp > 0 && done_cyc != done_drv + 1) begin
            n_errors++;
            $display("FAIL %s done_pulse_latency: got %0d required %0d", name, done_cyc - done_drv, 1);
        end

        @(posedge Clk); #1;
        n_checks++;
        if ({bus.busy_out, bus.layer_done_out} !== 2'b00) begin
            n_errors++;
            $display("FAIL %s after_done busy/done: got %b%b required 00", name, bus.busy_out, bus.layer_done_out);
        end
    endtask

    task automatic test_reset();
        drive_idle();
        Rst_n = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %h required 0", all_outs());
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        n_checks++;
        if (bus.busy_out !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_idle_busy: got %b required 0", bus.busy_out);
        end
    endtask

    task automatic test_two_groups();
        run_layer("two_groups", 2, 1, 32'h100, 32'h1000, 4, 5, 0);
    endtask

    task automatic test_one_group_three_oc();
        run_layer("one_group_3oc", 1, 3, 32'h2000, 32'h8000, 7, 3, 0);
    endtask

    task automatic test_empty_layers();
        run_layer("out_ch_zero", 3, 0, 32'h40, 32'h400, 5, 2, 0);
        run_layer("in_groups_zero", 0, 2, 32'h40, 32'h400, 5, 2, 0);
    endtask

    task automatic test_spurious();
        run_layer("spurious", 2, 2, 32'h300, 32'h5000, 6, 4, 1);
    endtask

    task automatic test_wrap();
        run_layer("wrap", 1, 2, 32'hFFFFFFF0, 32'hFFFFFF00, 8, 2, 0);
    endtask

    task automatic test_mid_reset();
        int cyc;
        logic t0;
        t0 = bus.inst_tag_out;
        bus.in_groups_in   = 10'd3;
        bus.out_ch_in      = 10'd2;
        bus.weight_base_in = 32'h700;
        bus.data_base_in   = 32'h9000;
        bus.pict_size_in   = 9'd10;
        bus.start_in       = 1'b1;
        cyc = 0;
        do begin
            @(posedge Clk); #1;
            bus.start_in = 1'b0;
            cyc++;
        end while (bus.inst_tag_out === t0 && cyc < 20);
        n_checks++;
        if (bus.inst_tag_out === t0) begin
            n_errors++;
            $display("FAIL mid_reset_first_toggle: got no toggle in %0d cycles, required toggle", cyc);
        end
        repeat (2) @(posedge Clk);
        #3;
        Rst_n = 1'b0;
        #1;
        n_checks++;
        if (all_outs() !== '0) begin
            n_errors++;
            $display("FAIL mid_reset_async: got %h required 0", all_outs());
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge Clk); #1;
            n_checks++;
            if (bus.layer_done_out !== 1'b0) begin
                n_errors++;
                $display("FAIL mid_reset_no_done cycle %0d: got %b required 0", i, bus.layer_done_out);
            end
        end
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        run_layer("after_reset", 2, 2, 32'h1234, 32'hA000, 3, 2, 0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 5; i++) begin
            run_layer("random", int'($urandom_range(1, 3)), int'($urandom_range(1, 3)),
                      $urandom, $urandom, int'($urandom_range(1, 511)),
                      int'($urandom_range(2, 5)), bit'($urandom_range(0, 1)));
        end
    endtask

    initial begin
        test_reset();
        test_two_groups();
        test_one_group_three_oc();
        test_empty_layers();
        test_spurious();
        test_mid_reset();
        test_wrap();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/conv_layer_seq.md
Name: conv_layer_seq

Overview:
- Layer-level scheduler that sequences the convolution controller through a whole layer: every output channel × every 4-channel input group.
- Per instruction it generates the four kernel base addresses and four input-plane base addresses, plus `pict_size`, `conv_first` and `conv_last`.
- It toggles `inst_tag` and waits for a completion pulse before issuing the next instruction.
- Sits between the layer-config registers (host side) and the convolution controller's instruction inputs.

Parameters:
- MaxAddrWidth, 32, width of all address ports
- MaxPictWidth, 9, width of picture side length
- MaxPixelNum, 18, width of pixel count (side²)
- MaxChWidth, 10, width of channel/group counters
- KernelSize, 9, weights per kernel (3×3)
- InputDim, 4, input channels consumed per instruction

Ports:
- Clk  in  1  single clock
- Rst_n  in  1  asynchronous active-low reset
- start_in  in  1  one-cycle layer start pulse
- in_groups_in  in  MaxChWidth  number of input-channel groups (input channels / InputDim)
- out_ch_in  in  MaxChWidth  number of output channels
- weight_base_in  in  MaxAddrWidth  first weight word of layer
- data_base_in  in  MaxAddrWidth  first input-plane word of layer
- pict_size_in  in  MaxPictWidth  picture side length
- conv_done_in  in  1  one-cycle pulse: current instruction finished
- weight_addr0_out..weight_addr3_out  out  MaxAddrWidth each  kernel base for channel k of group
- data_addr0_out..data_addr3_out  out  MaxAddrWidth each  plane base for channel k of group
- pict_size_out  out  MaxPictWidth  latched side length
- conv_first_out  out  1  first group of an output channel
- conv_last_out  out  1  last group of an output channel
- inst_tag_out  out  1  toggles once per issued instruction
- busy_out  out  1  layer in progress
- layer_done_out  out  1  one-cycle pulse at layer end

Behaviour:
- Reset values (async, Rst_n=0): all address outputs 0, pict_size_out 0, conv_first_out 0, conv_last_out 0, inst_tag_out 0, busy_out 0, layer_done_out 0, state IDLE.
- IDLE:
  - On start_in, latch all config inputs and go to SETUP; busy_out rises the next cycle.
  - start_in outside IDLE is ignored.
- SETUP (1 cycle):
  - pix_num = pict_size²; pix_num is truncated to MaxPixelNum bits.
  - Zero counters: oc = 0, g = 0; w_ptr = weight_base; d_ptr = data_base.
  - If in_groups == 0 or out_ch == 0, go to DONE with no instruction issued.
  - Otherwise go to ISSUE.
- ISSUE (1 cycle), registered outputs updated:
  - weight_addrk = w_ptr + k·KernelSize.
  - data_addrk = d_ptr + k·pix_num.
  - conv_first = (g == 0); conv_last = (g == in_groups−1).
  - inst_tag toggles; go to WAIT.
  - Outputs hold stable until the next ISSUE.
- WAIT: wait for conv_done_in; a pulse in any other state is ignored. On the pulse:
  - w_ptr += InputDim·KernelSize.
  - If g < in_groups−1: g++, d_ptr += InputDim·pix_num.
  - Else: g = 0, d_ptr = data_base, oc++.
  - If oc was out_ch−1 and g was last, go to DONE; otherwise go to ISSUE.
- DONE (1 cycle): layer_done_out = 1, busy_out falls next cycle, return to IDLE.
- Latency: start → first tag toggle = 3 cycles; conv_done → next toggle = 2 cycles.
- Arithmetic:
  - All address sums are unsigned, modulo 2^MaxAddrWidth (wrap, no flag).
  - Multiplications by constants only; the single pix_num square is registered.
- Reset mid-layer: immediate return to IDLE, all outputs to reset values, no layer_done.

Optional Feature:
- Macro CONV_SEQ_PERF_EN.
- Defined:
  - Extra outputs perf_cycles_out (32 bit) and perf_insts_out (MaxChWidth·2 bit).
  - Both clear on start acceptance.
  - perf_cycles counts cycles with busy_out = 1.
  - perf_insts counts ISSUE cycles.
  - Both hold their values after DONE.
- Undefined: ports and counters absent; no other behaviour change.

Decomposition:
- Shared package: state encoding (IDLE, SETUP, ISSUE, WAIT, DONE), the InputDim·KernelSize weight stride constant, default widths.
- One natural sub-module, conv_addr_gen: given w_ptr, d_ptr and pix_num, produces the eight registered addresses.
- FSM and counters stay in the top module.

Test Plan:
- in_groups=2, out_ch=1, weight_base=0x100, data_base=0x1000, pict=4, done pulses 5 cycles after each toggle:
  - First instruction: weight 0x100/0x109/0x112/0x11B, data 0x1000/0x1010/0x1020/0x1030, first=1, last=0.
  - Second instruction: weight 0x124…, data 0x1040…, first=0, last=1.
  - Then layer_done pulse; two tag toggles total.
- in_groups=1, out_ch=3: three instructions, each first=1 and last=1; data_addr0 = data_base every time; weight_addr0 advances by 36 each time.
- out_ch=0: no tag toggle, layer_done 2 cycles after start, busy high for exactly 2 cycles.
- start_in re-asserted during WAIT and a spurious conv_done_in during ISSUE: both ignored; instruction count unchanged.
- Rst_n pulled low mid-WAIT: outputs read 0 within the same cycle (asynchronous); a new start after release restarts from oc=0, g=0.
- weight_base=0xFFFFFFF0: weight_addr2 wraps to 0x00000002, with no stall.
